// File: rtl/uart_mike_pkg.sv
// uart_mike_pkg: shared constants, FSM state types and the parity helper
// for the uart_mike transceiver.
//   UART_DATA_WIDTH : data bits per frame
//   CLKS_PER_BIT    : clk cycles per serial bit
package uart_mike_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int CLKS_PER_BIT    = 10;

  // Counter widths derived from the constants above.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_WIDTH);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Even parity bit: makes data plus parity hold an even number of ones.
  function automatic logic even_parity(input logic [UART_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_mike_if.sv
// uart_mike_if: groups the uart_mike data/serial signals.
//   master : the side that supplies tx_data/tx_send/rx/rx_flag_clr
//   slave  : the uart_mike transceiver itself
interface uart_mike_if;
  import uart_mike_pkg::*;

  logic [UART_DATA_WIDTH-1:0] tx_data;
  logic                       tx_send;
  logic                       rx;
  logic                       rx_flag_clr;
  logic                       tx;
  logic                       parity_error;
  logic                       rx_flag;
  logic [UART_DATA_WIDTH-1:0] rx_data;

  modport master (
    output tx_data, tx_send, rx, rx_flag_clr,
    input  tx, parity_error, rx_flag, rx_data
  );

  modport slave (
    input  tx_data, tx_send, rx, rx_flag_clr,
    output tx, parity_error, rx_flag, rx_data
  );

endinterface

// File: rtl/uart_mike_rx.sv
// uart_mike_rx: UART receiver (start, data LSB first, even parity, stop).
//   clk, n_rst      : clock, async active-low reset
//   rx_i            : asynchronous serial input, idle high
//   rx_flag_clr_i   : clears the sticky frame-received flag
//   rx_data_o       : last received data word
//   parity_error_o  : parity result of the last received frame
//   rx_flag_o       : sticky frame-received flag
module uart_mike_rx
  import uart_mike_pkg::*;
(
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       rx_i,
  input  logic                       rx_flag_clr_i,
  output logic [UART_DATA_WIDTH-1:0] rx_data_o,
  output logic                       parity_error_o,
  output logic                       rx_flag_o
);

  logic                       sync1_q, sync2_q;
  rx_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       par_q, par_d;
  logic [UART_DATA_WIDTH-1:0] data_q, data_d;
  logic                       perr_q, perr_d;
  logic                       flag_q, flag_d;
  logic                       bit_end_s, half_end_s, done_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign bit_end_s  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_end_s = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));

  // Next-state logic: half-bit wait to the start midpoint, then full bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_s  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (half_end_s) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A high line at the start midpoint was only a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[UART_DATA_WIDTH-1:1]};
          if (bit_q == BIT_W'(UART_DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = RX_PARITY;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          par_d   = sync2_q;
          state_d = RX_STOP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          done_s  = 1'b1;
          // A low stop bit still completes the frame, but the line must
          // go idle before another start can be recognised.
          state_d = sync2_q ? RX_IDLE : RX_WAIT_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (sync2_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_WAIT_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Result registers update only on frame completion; set beats clear.
  always_comb begin
    data_d = data_q;
    perr_d = perr_q;
    flag_d = flag_q;
    if (done_s) begin
      data_d = shift_q;
      perr_d = (par_q != even_parity(shift_q));
      flag_d = 1'b1;
    end else if (rx_flag_clr_i) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      flag_q  <= flag_d;
    end
  end

  assign rx_data_o      = data_q;
  assign parity_error_o = perr_q;
  assign rx_flag_o      = flag_q;

endmodule

// File: rtl/uart_mike.sv
// uart_mike: UART transceiver, 8E1-style frames at CLKS_PER_BIT clocks/bit.
//   clk   : single clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : uart_mike_if.slave -- tx_data/tx_send/rx/rx_flag_clr in,
//           tx/parity_error/rx_flag/rx_data out
// The transmitter lives here; the receiver is uart_mike_rx.
module uart_mike
  import uart_mike_pkg::*;
(
  input  logic      clk,
  input  logic      n_rst,
  uart_mike_if.slave bus
);

  tx_state_e                  tx_state_q, tx_state_d;
  logic [CNT_W-1:0]           tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]           tx_bit_q, tx_bit_d;
  logic [UART_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                       tx_q, tx_d;
  logic                       tx_bit_end_s;

  assign tx_bit_end_s = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // TX next state: tx_send is only looked at in IDLE.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_send) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.tx_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tx_bit_end_s) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end_s) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_W'(UART_DATA_WIDTH - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = TX_PARITY;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (tx_bit_end_s) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_bit_end_s) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // Line level follows the next state so tx changes on the same edge
  // as the state, keeping the output registered.
  always_comb begin
    case (tx_state_d)
      TX_IDLE:   tx_d = 1'b1;
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[tx_bit_d];
      TX_PARITY: tx_d = even_parity(tx_shift_d);
      TX_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx = tx_q;

  uart_mike_rx u_rx (
    .clk            (clk),
    .n_rst          (n_rst),
    .rx_i           (bus.rx),
    .rx_flag_clr_i  (bus.rx_flag_clr),
    .rx_data_o      (bus.rx_data),
    .parity_error_o (bus.parity_error),
    .rx_flag_o      (bus.rx_flag)
  );

endmodule

// File: tb/tb_uart_mike.sv
// tb_uart_mike: directed + randomized bench for uart_mike with a
// frame-level reference model (frames built as bit vectors, parity from
// a population count).
module tb_uart_mike;
  import uart_mike_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  logic rx_drv;
  logic loop_en;
  int   checks   = 0;
  int   failures = 0;

  uart_mike_if bus ();

  assign bus.rx = loop_en ? bus.tx : rx_drv;

  uart_mike dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Even-parity bit of a byte: 1 when the byte has an odd count of ones.
  function automatic logic ref_parity(input logic [7:0] d);
    return (($countones(d) % 2) == 1);
  endfunction

  // Frame as sent on the line, bit 0 first.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on rx, CLKS_PER_BIT cycles per bit, from a negedge.
  task automatic send_rx(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat (CLKS_PER_BIT) @(negedge clk);
    end
  endtask

  task automatic clear_flag();
    bus.rx_flag_clr = 1'b1;
    @(negedge clk);
    bus.rx_flag_clr = 1'b0;
  endtask

  // Pulse tx_send and check every bit of the frame at its midpoint.
  task automatic tx_frame(input logic [7:0] d, input bit resend);
    logic [10:0] exp;
    int          idle_bad;
    exp = ref_frame(d, ref_parity(d), 1'b1);
    bus.tx_data = d;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    chk("tx_start_edge", 32'(bus.tx), 32'(1'b0));
    repeat (5) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("tx_bit%0d_%02h", k, d), 32'(bus.tx), 32'(exp[k]));
      if (resend && k == 3) begin
        bus.tx_data = ~d;
        bus.tx_send = 1'b1;
        @(negedge clk);
        bus.tx_send = 1'b0;
        repeat (CLKS_PER_BIT - 1) @(negedge clk);
      end else begin
        repeat (CLKS_PER_BIT) @(negedge clk);
      end
    end
    idle_bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.tx !== 1'b1) idle_bad++;
      @(negedge clk);
    end
    chk("tx_idle_after_frame", 32'(idle_bad), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       bad;
    logic       stp;
    n_rst           = 1'b0;
    rx_drv          = 1'b1;
    loop_en         = 1'b0;
    bus.tx_data     = 8'h00;
    bus.tx_send     = 1'b0;
    bus.rx_flag_clr = 1'b0;

    // Reset for 20 ns, then idle.
    #20;
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(bus.tx), 32'(1'b1));
    chk("rst_rx_flag", 32'(bus.rx_flag), 32'(1'b0));
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_parity_error", 32'(bus.parity_error), 32'(1'b0));

    // Data 0x01 with parity 0 (wrong) and a low stop bit, line held low.
    send_rx(11'b000_0000_0010);
    chk("lowstop_flag", 32'(bus.rx_flag), 32'(1'b1));
    chk("lowstop_data", 32'(bus.rx_data), 32'h01);
    chk("lowstop_perr", 32'(bus.parity_error), 32'(1'b1));
    clear_flag();
    repeat (150) @(negedge clk);
    chk("wait_idle_no_frame", 32'(bus.rx_flag), 32'(1'b0));
    chk("wait_idle_data_held", 32'(bus.rx_data), 32'h01);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);

    // Good 0xA5 frame, then a 6-cycle clear pulse.
    send_rx(ref_frame(8'hA5, ref_parity(8'hA5), 1'b1));
    chk("a5_flag", 32'(bus.rx_flag), 32'(1'b1));
    chk("a5_data", 32'(bus.rx_data), 32'hA5);
    chk("a5_perr", 32'(bus.parity_error), 32'(1'b0));
    bus.rx_flag_clr = 1'b1;
    @(negedge clk);
    chk("clr_one_edge", 32'(bus.rx_flag), 32'(1'b0));
    repeat (5) @(negedge clk);
    bus.rx_flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_flag_stays", 32'(bus.rx_flag), 32'(1'b0));
    chk("clr_data_held", 32'(bus.rx_data), 32'hA5);

    // Randomized received frames: parity right/wrong, stop high/low,
    // flag left set on odd passes so new frames overwrite data.
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      bad = 1'($urandom_range(0, 1));
      stp = 1'($urandom_range(0, 1));
      send_rx(ref_frame(d, ref_parity(d) ^ bad, stp));
      rx_drv = 1'b1;
      repeat (5) @(negedge clk);
      chk($sformatf("rnd%0d_flag", i), 32'(bus.rx_flag), 32'(1'b1));
      chk($sformatf("rnd%0d_data", i), 32'(bus.rx_data), 32'(d));
      chk($sformatf("rnd%0d_perr", i), 32'(bus.parity_error), 32'(bad));
      if (i % 2 == 0) clear_flag();
    end
    clear_flag();

    // Transmit 0x3C with an ignored resend, then random bytes.
    tx_frame(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tx_frame(8'($urandom), 1'b0);
    end

    // tx_send held high: next start bit follows one idle cycle after
    // the 110-cycle frame.
    d = 8'($urandom);
    bus.tx_data = d;
    bus.tx_send = 1'b1;
    @(negedge clk);
    chk("held_start", 32'(bus.tx), 32'(1'b0));
    repeat (110) @(negedge clk);
    chk("held_gap_idle", 32'(bus.tx), 32'(1'b1));
    @(negedge clk);
    chk("held_restart", 32'(bus.tx), 32'(1'b0));
    bus.tx_send = 1'b0;
    repeat (120) @(negedge clk);

    // Loopback of 0x80.
    loop_en = 1'b1;
    bus.tx_data = 8'h80;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    repeat (125) @(negedge clk);
    chk("loop_flag", 32'(bus.rx_flag), 32'(1'b1));
    chk("loop_data", 32'(bus.rx_data), 32'h80);
    chk("loop_perr", 32'(bus.parity_error), 32'(1'b0));
    loop_en = 1'b0;
    clear_flag();

    // Short low glitch on an idle line.
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_flag", 32'(bus.rx_flag), 32'(1'b0));
    chk("glitch_data_held", 32'(bus.rx_data), 32'h80);

    // Reset in the middle of both a TX and an RX frame.
    bus.tx_data = 8'h00;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    rx_drv = 1'b0;
    repeat (35) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_tx", 32'(bus.tx), 32'(1'b1));
    chk("midrst_flag", 32'(bus.rx_flag), 32'(1'b0));
    chk("midrst_data", 32'(bus.rx_data), 32'h00);
    chk("midrst_perr", 32'(bus.parity_error), 32'(1'b0));
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (150) @(negedge clk);
    chk("postrst_no_flag", 32'(bus.rx_flag), 32'(1'b0));
    chk("postrst_tx_idle", 32'(bus.tx), 32'(1'b1));

    // Normal operation resumes after reset.
    d = 8'($urandom);
    send_rx(ref_frame(d, ref_parity(d), 1'b1));
    chk("resume_flag", 32'(bus.rx_flag), 32'(1'b1));
    chk("resume_data", 32'(bus.rx_data), 32'(d));
    chk("resume_perr", 32'(bus.parity_error), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
